// File: rtl/hazard_track_pipe.sv
// Hazard-tracking shift chain for the E..W stages of the 5-stage core.
// Also produces forwarding selects and the Tuse/Tnew stall request for D.
module hazard_track_pipe #(
    parameter int AW    = 5,
    parameter int RW    = 3,
    parameter int TW    = 2,
    parameter int NRD   = 2,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    // in_valid qualifies the D fields; there is no ready: the D instruction
    // enters E on an edge with in_valid=1 and stall, flush, hold, rst all 0.
    input  logic                     in_valid,
    input  logic [NRD*AW-1:0]        in_ra,
    input  logic [AW-1:0]            in_wa,
    input  logic [RW-1:0]            in_res,
    input  logic [TW-1:0]            in_tnew,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     hold,
    input  logic [NRD*TW-1:0]        q_tuse,
    input  logic [NRD-1:0]           q_use,
    output logic [DEPTH-1:0]         st_valid,
    output logic [DEPTH*NRD*AW-1:0]  st_ra,
    output logic [DEPTH*AW-1:0]      st_wa,
    output logic [DEPTH*RW-1:0]      st_res,
    output logic [DEPTH*TW-1:0]      st_tnew,
    output logic [NRD-1:0]           fwd_hit,
    output logic [NRD*SW-1:0]        fwd_stage,
    output logic                     stall_req
);

    localparam int RAW = NRD * AW;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [RAW-1:0]   ra_q   [DEPTH];
    logic [RAW-1:0]   ra_d   [DEPTH];
    logic [AW-1:0]    wa_q   [DEPTH];
    logic [AW-1:0]    wa_d   [DEPTH];
    logic [RW-1:0]    res_q  [DEPTH];
    logic [RW-1:0]    res_d  [DEPTH];
    logic [TW-1:0]    tnew_q [DEPTH];
    logic [TW-1:0]    tnew_d [DEPTH];
    logic             load;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    always_comb begin
        valid_d = valid_q;
        ra_d    = ra_q;
        wa_d    = wa_q;
        res_d   = res_q;
        tnew_d  = tnew_q;
        load    = in_valid & ~stall & ~flush;
        if (!hold) begin
            // Stall and flush both collapse to a single bubble in E.
            valid_d[0] = load;
            ra_d[0]    = load ? in_ra   : '0;
            wa_d[0]    = load ? in_wa   : '0;
            res_d[0]   = load ? in_res  : '0;
            tnew_d[0]  = load ? in_tnew : '0;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ra_d[k]    = ra_q[k-1];
                wa_d[k]    = wa_q[k-1];
                res_d[k]   = res_q[k-1];
                tnew_d[k]  = sat_dec(tnew_q[k-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ra_q[k]   <= '0;
                wa_q[k]   <= '0;
                res_q[k]  <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ra_q    <= ra_d;
            wa_q    <= wa_d;
            res_q   <= res_d;
            tnew_q  <= tnew_d;
        end
    end

    assign st_valid = valid_q;
    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign st_ra[k*RAW +: RAW] = ra_q[k];
        assign st_wa[k*AW +: AW]   = wa_q[k];
        assign st_res[k*RW +: RW]  = res_q[k];
        assign st_tnew[k*TW +: TW] = tnew_q[k];
    end

    // Depends only on registered state and D fields, never on stall.
    always_comb begin
        logic [AW-1:0] addr;
        logic          hit;
        logic [SW-1:0] sel;
        logic [TW-1:0] sel_tnew;
        fwd_hit   = '0;
        fwd_stage = '0;
        stall_req = 1'b0;
        addr      = '0;
        hit       = 1'b0;
        sel       = '0;
        sel_tnew  = '0;
        for (int i = 0; i < NRD; i++) begin
            addr     = in_ra[i*AW +: AW];
            hit      = 1'b0;
            sel      = '0;
            sel_tnew = '0;
            // Scan oldest to youngest so the youngest producer wins.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_q[k] && (wa_q[k] == addr) && (addr != '0)) begin
                    hit      = 1'b1;
                    sel      = SW'(k);
                    sel_tnew = tnew_q[k];
                end
            end
            fwd_hit[i]             = hit;
            fwd_stage[i*SW +: SW]  = sel;
            if (q_use[i] && hit && (sel_tnew > q_tuse[i*TW +: TW])) begin
                stall_req = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Bench for hazard_track_pipe: directed test-plan scenarios, then random
// traffic checked against a small stage model and a retire scoreboard.
module tb_hazard_track_pipe;

    localparam int AW    = 5;
    localparam int RW    = 3;
    localparam int TW    = 2;
    localparam int NRD   = 2;
    localparam int DEPTH = 3;
    localparam int SW    = $clog2(DEPTH);
    localparam int EW    = NRD*AW + AW + RW + TW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [NRD*AW-1:0]       in_ra;
    logic [AW-1:0]           in_wa;
    logic [RW-1:0]           in_res;
    logic [TW-1:0]           in_tnew;
    logic                    stall;
    logic                    flush;
    logic                    hold;
    logic [NRD*TW-1:0]       q_tuse;
    logic [NRD-1:0]          q_use;
    logic [DEPTH-1:0]        st_valid;
    logic [DEPTH*NRD*AW-1:0] st_ra;
    logic [DEPTH*AW-1:0]     st_wa;
    logic [DEPTH*RW-1:0]     st_res;
    logic [DEPTH*TW-1:0]     st_tnew;
    logic [NRD-1:0]          fwd_hit;
    logic [NRD*SW-1:0]       fwd_stage;
    logic                    stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    // Reference stage model (valid, destination, remaining Tnew).
    int m_valid [DEPTH];
    int m_wa    [DEPTH];
    int m_tnew  [DEPTH];

    hazard_track_pipe #(
        .AW(AW), .RW(RW), .TW(TW), .NRD(NRD), .DEPTH(DEPTH), .SW(SW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ra(in_ra),
        .in_wa(in_wa), .in_res(in_res), .in_tnew(in_tnew),
        .stall(stall), .flush(flush), .hold(hold),
        .q_tuse(q_tuse), .q_use(q_use),
        .st_valid(st_valid), .st_ra(st_ra), .st_wa(st_wa),
        .st_res(st_res), .st_tnew(st_tnew),
        .fwd_hit(fwd_hit), .fwd_stage(fwd_stage), .stall_req(stall_req)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] tnew_at_w(input logic [TW-1:0] t);
        int v;
        v = int'(t) - (DEPTH - 1);
        return (v < 0) ? '0 : TW'(v);
    endfunction

    task automatic model_step(input logic acc);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 0; m_wa[k] = 0; m_tnew[k] = 0;
            end
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_wa[k]    = m_wa[k-1];
                m_tnew[k]  = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
            end
            m_valid[0] = acc ? 1 : 0;
            m_wa[0]    = acc ? int'(in_wa) : 0;
            m_tnew[0]  = acc ? int'(in_tnew) : 0;
        end
    endtask

    // One clock: scoreboard push, model update, edge, retire check.
    task automatic tick();
        logic acc, adv;
        logic [EW-1:0] e;
        acc = !rst && !hold && in_valid && !stall && !flush;
        adv = !rst && !hold;
        if (rst) exp_q.delete();
        else if (acc) exp_q.push_back({in_ra, in_wa, in_res, tnew_at_w(in_tnew)});
        model_step(acc);
        @(posedge clk);
        #1;
        if (adv && st_valid[DEPTH-1]) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_retire", {st_ra[(DEPTH-1)*NRD*AW +: NRD*AW],
                                    st_wa[(DEPTH-1)*AW +: AW],
                                    st_res[(DEPTH-1)*RW +: RW],
                                    st_tnew[(DEPTH-1)*TW +: TW]}, e);
            end
        end
    endtask

    task automatic issue(input int wa, input int tnew);
        in_valid = 1'b1;
        in_wa    = AW'(wa);
        in_tnew  = TW'(tnew);
        in_res   = RW'($urandom_range(0, 7));
        in_ra    = (NRD*AW)'($urandom_range(0, 1023));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_query(input string tag);
        logic [NRD-1:0]    e_hit;
        logic [NRD*SW-1:0] e_stage;
        logic              e_stall;
        int                a;
        e_hit = '0; e_stage = '0; e_stall = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a = int'(in_ra[i*AW +: AW]);
            for (int k = 0; k < DEPTH; k++) begin
                if (!e_hit[i] && a != 0 && m_valid[k] == 1 && m_wa[k] == a) begin
                    e_hit[i] = 1'b1;
                    e_stage[i*SW +: SW] = SW'(k);
                    if (q_use[i] && m_tnew[k] > int'(q_tuse[i*TW +: TW]))
                        e_stall = 1'b1;
                end
            end
        end
        check({tag, "_hit"}, fwd_hit, e_hit);
        check({tag, "_stage"}, fwd_stage, e_stage);
        check({tag, "_stall"}, stall_req, e_stall);
    endtask

    task automatic check_stages(input string tag);
        logic [DEPTH-1:0]    e_v;
        logic [DEPTH*AW-1:0] e_wa;
        logic [DEPTH*TW-1:0] e_t;
        for (int k = 0; k < DEPTH; k++) begin
            e_v[k]            = (m_valid[k] == 1);
            e_wa[k*AW +: AW]  = AW'(m_wa[k]);
            e_t[k*TW +: TW]   = TW'(m_tnew[k]);
        end
        check({tag, "_valid"}, st_valid, e_v);
        check({tag, "_wa"}, st_wa, e_wa);
        check({tag, "_tnew"}, st_tnew, e_t);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ra = '0; in_wa = '0; in_res = '0;
        in_tnew = '0; stall = 1'b0; flush = 1'b0; hold = 1'b0;
        q_tuse = '0; q_use = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle
        for (int c = 0; c < 4; c++) tick();
        check("idle_valid", st_valid, 0);
        check("idle_ra", st_ra, 0);
        check("idle_wa", st_wa, 0);
        check("idle_res", st_res, 0);
        check("idle_tnew", st_tnew, 0);
        check("idle_fwd_hit", fwd_hit, 0);
        check("idle_fwd_stage", fwd_stage, 0);
        check("idle_stall_req", stall_req, 0);

        // Shift and countdown
        issue(8, 2);
        check("shift_v0", st_valid, 3'b001);
        check("shift_t0", st_tnew[1:0], 2);
        tick();
        check("shift_v1", st_valid, 3'b010);
        check("shift_wa1", st_wa[9:5], 8);
        check("shift_t1", st_tnew[3:2], 1);
        tick();
        check("shift_v2", st_valid, 3'b100);
        check("shift_t2", st_tnew[5:4], 0);
        tick();
        check("shift_gone", st_valid, 3'b000);

        // Load-use hazard
        issue(5, 2);
        in_valid = 1'b1; in_wa = 6; in_tnew = 0; in_res = 1;
        in_ra = {5'd0, 5'd5}; q_use = 2'b01; q_tuse = {2'd0, 2'd1};
        #1;
        check("lu_hit", fwd_hit, 2'b01);
        check("lu_stage", fwd_stage[1:0], 0);
        check("lu_stall", stall_req, 1);
        stall = 1'b1;
        tick();
        check("lu_m_hit", fwd_hit, 2'b01);
        check("lu_m_stage", fwd_stage[1:0], 1);
        check("lu_m_stall", stall_req, 0);
        stall = 1'b0;
        tick();
        in_valid = 1'b0; q_use = '0; q_tuse = '0;
        for (int c = 0; c < 3; c++) tick();

        // Youngest producer wins; $0 never matches
        issue(3, 1);
        issue(3, 1);
        in_ra = {5'd3, 5'd0};
        #1;
        check("yw_hit", fwd_hit, 2'b10);
        check("yw_stage", fwd_stage[3:2], 0);
        issue(0, 1);
        in_ra = {5'd3, 5'd0};
        #1;
        check("z_entry_valid", st_valid[0], 1);
        check("z_entry_wa", st_wa[4:0], 0);
        check("z_hit", fwd_hit, 2'b10);
        check("z_stage", fwd_stage[3:2], 1);
        for (int c = 0; c < 3; c++) tick();

        // Hold beats flush; then flush inserts one bubble
        issue(10, 3); issue(11, 3); issue(12, 3);
        check("hf_valid0", st_valid, 3'b111);
        check("hf_wa0", st_wa, {5'd10, 5'd11, 5'd12});
        check("hf_tnew0", st_tnew, {2'd1, 2'd2, 2'd3});
        hold = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_wa = 13; in_tnew = 3; in_res = 2; in_ra = '0;
        tick(); tick();
        check("hf_valid_held", st_valid, 3'b111);
        check("hf_wa_held", st_wa, {5'd10, 5'd11, 5'd12});
        check("hf_tnew_held", st_tnew, {2'd1, 2'd2, 2'd3});
        hold = 1'b0;
        tick();
        check("hf_valid_fl", st_valid, 3'b110);
        check("hf_wa_fl", st_wa, {5'd11, 5'd12, 5'd0});
        check("hf_tnew_fl", st_tnew, {2'd1, 2'd2, 2'd0});
        flush = 1'b0;
        tick();
        check("hf_resume_wa0", st_wa[4:0], 13);
        in_valid = 1'b0;

        // Reset mid-operation under hold
        issue(7, 3); issue(9, 2); issue(4, 1);
        hold = 1'b1; rst = 1'b1;
        tick();
        check("rst_valid", st_valid, 0);
        check("rst_ra", st_ra, 0);
        check("rst_wa", st_wa, 0);
        check("rst_res", st_res, 0);
        check("rst_tnew", st_tnew, 0);
        rst = 1'b0; hold = 1'b0;
        tick();

        // Random traffic against the stage model and scoreboard
        for (int c = 0; c < 300; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            hold     = ($urandom_range(0, 99) < 15);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            in_valid = ($urandom_range(0, 99) < 75);
            in_wa    = AW'($urandom_range(0, 7));
            in_res   = RW'($urandom_range(0, 7));
            in_tnew  = TW'($urandom_range(0, 3));
            in_ra    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            q_use    = NRD'($urandom_range(0, 3));
            q_tuse   = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            #1;
            check_query("rnd_q");
            tick();
            check_stages("rnd_st");
        end

        rst = 1'b0; hold = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; q_use = '0;
        for (int c = 0; c < DEPTH; c++) tick();
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
